// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 set-2 scan-code decoder feeding a show-ahead event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the held make code.
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  input  logic       clr_ovf,
  output logic [7:0] last_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          emit, emit_ext, emit_brk;
  logic          is_e0, is_f0, is_junk;
  logic          push;

  assign is_e0   = (rx_data == 8'hE0);
  assign is_f0   = (rx_data == 8'hF0);
  // Controller responses and overrun codes never become key events.
  assign is_junk = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hE1) ||
                   (rx_data == 8'hEE) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                   (rx_data == 8'hFF);
  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_valid) begin
      if (rx_err) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_e0)         state_d = S_EXT;
            else if (is_f0)    state_d = S_BRK;
            else if (!is_junk) emit = 1'b1;
          end
          S_EXT: begin
            if (is_f0)      state_d = S_EXT_BRK;
            else if (!is_e0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = S_IDLE;
            end
          end
          S_BRK: begin
            if (is_e0)      state_d = S_EXT;
            else if (!is_f0) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: begin
            if (!is_e0 && !is_f0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_brk = 1'b1;
              state_d  = S_IDLE;
            end
          end
        endcase
      end
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_vld_q, held_ext_q;
  logic [7:0] held_code_q;
  logic       held_match;

  assign held_match = held_vld_q && (held_ext_q == emit_ext) && (held_code_q == rx_data);
  assign push       = emit && (emit_brk || !held_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_vld_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
    end else if (emit) begin
      if (!emit_brk) begin
        held_vld_q  <= 1'b1;
        held_ext_q  <= emit_ext;
        held_code_q <= rx_data;
      end else if (held_match) begin
        held_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  logic [AW:0] wptr_q, rptr_q;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, pop, wr;
  logic        ovf_q;
  logic [7:0]  last_q;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (rx_valid || state_q == S_IDLE || tmo_hit) tmo_q <= '0;
      else                                          tmo_q <= tmo_q + TW'(1);
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf)         ovf_q <= 1'b0;
      if (emit) last_q <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= {emit_ext, emit_brk, rx_data};
  end

  assign {ev_ext, ev_brk, ev_code} = mem_q[rptr_q[AW-1:0]];
  assign ev_valid  = !empty;
  assign overflow  = ovf_q;
  assign last_code = last_q;

endmodule
